lane_note_engine: RTL and testbench
===================================

Name: lane_note_engine

Overview:
Parameterised successor to the fixed three-instance pattern/score arrangement in the rhythm-game top level. It owns N_LANES note lanes, with one falling note slot per lane. Each lane spawns notes from the pattern list via a valid/ready handshake, moves them once per frame, judges key presses against a hit window, and keeps score and combo with a multiplier. It sits between the pattern list manager, the KEY inputs, the VGA pixel scan (next_x/next_y) and the placar display.

Parameters:
N_LANES, 4, number of lanes (1..8)
Y_W, 10, note y-position width
SPEED, 2, pixels moved per frame_tick
HIT_Y, 450, target line y
HIT_WIN, 16, half-width of the hit window in pixels
NOTE_H, 32, note height in pixels
X0, 160, left x of lane 0
LANE_W, 80, lane width in pixels
SCORE_W, 16, score width

Ports:
CLOCK_25  in  1  pixel clock; the only clock
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame from vga
spawn_valid  in  1  pattern list offers a spawn
spawn_lanes  in  N_LANES  bitmask of lanes receiving a new note
spawn_ready  out  1  spawn accepted when spawn_valid && spawn_ready
key_in  in  N_LANES  per-lane button level, active-high, already synchronised
next_x  in  10  scan x
next_y  in  10  scan y
pixel_lane  out  N_LANES  lane i's note covers the scan pixel
score  out  SCORE_W  accumulated score
combo  out  8  current combo count
hit_pulse  out  N_LANES  one-cycle pulse per lane hit
miss_pulse  out  N_LANES  one-cycle pulse per lane miss

Behaviour:
- Reset: all slots inactive, y=0; score=0, combo=0, all pulses=0, pixel_lane=0, key edge registers=0.
- spawn_ready = !frame_tick && ((spawn_lanes & active) == 0). On acceptance, each selected lane becomes active with y=0 on the next cycle. spawn_lanes == 0 with valid is accepted as a no-op.
- Motion: on frame_tick, every active lane that is not hit in the same cycle gets y += SPEED.
- Miss: after the move, if y > HIT_Y+HIT_WIN, the lane is cleared and miss_pulse[i] asserts the following cycle. y never exceeds 2^Y_W-1 under defaults.
- Hit: a rising edge of key_in[i] (key_in & ~key_q) while lane i is active and HIT_Y-HIT_WIN <= y <= HIT_Y+HIT_WIN clears the lane and pulses hit_pulse[i]. Hits are judged on the pre-tick y. A hit in the same cycle as frame_tick wins and the note does not move.
- A key edge with no note in the window has no effect, unless GHOST_PENALTY_EN is defined.
- Points per hit = min(1 + (combo>>3), 4), using the combo value at the start of the cycle.
- Multiple hits in one cycle add the sum of their points.
- Score saturates at 2^SCORE_W-1.
- Combo update: 0 if any miss occurs in the cycle; otherwise combo + number of hits, saturating at 255.
- Latency: key edge to hit_pulse/score update is 1 cycle. Pulses last exactly 1 cycle.
- pixel_lane[i] is registered (1-cycle latency from next_x/next_y). It is high when:
  - lane i is active,
  - X0+i*LANE_W <= next_x < X0+(i+1)*LANE_W,
  - y <= next_y < y+NOTE_H.
- A reset asserted mid-flight clears everything on that edge, with no pulses emitted.

Optional Feature:
GHOST_PENALTY_EN.
- Defined: a key rising edge on a lane with no note in the window resets combo to 0. Score is unchanged and no pulse is emitted.
- Not defined: ghost presses are ignored.

Decomposition:
- Package lane_pkg: MAX_MULT=4, COMBO_W=8, COMBO_SHIFT=3, and the saturating-add helper function.
- Sub-module lane_slot, one instance per lane via generate:
  - holds active, y and the key edge register;
  - outputs hit, miss and in_pixel.
- Top-level logic: handshake, score/combo adder tree, pulse registers.

Test Plan:
- Spawn lane 0, 220 frame_ticks (y=440), press key 0 -> hit_pulse[0] 1 cycle later, score=1, combo=1.
- Spawn lane 1, no press -> miss_pulse[1] on tick 234 (y=468), combo from 5 -> 0, score unchanged.
- Spawn lane 2 with lane 2 active -> spawn_ready=0. Assert spawn_valid during frame_tick -> spawn_ready=0. Spawn lane 3 instead -> accepted.
- 8 consecutive hits, then 9th hit -> score 8 -> 10 (points=2). Combo 31 -> 32 gives points capped at 4. Score preloaded near max saturates at 65535.
- Same-cycle hits on lanes 0 and 2 plus miss on lane 1, combo=8 -> score += 4, combo=0. Hit coincident with frame_tick -> hit counted, y not advanced.
- Reset mid-flight with 3 active notes -> all slots cleared, score/combo=0, no pulses. GHOST_PENALTY_EN build: ghost press at combo=6 -> combo=0.

Source files
------------

// File: rtl/lane_pkg.sv
// lane_pkg
//   Shared constants and helpers for the note lane engine.
//   MAX_MULT    : cap on points awarded per hit
//   COMBO_W     : width of the combo counter
//   COMBO_SHIFT : combo is divided by 2^COMBO_SHIFT to form the multiplier step
//   sat_add     : unsigned add clamped to a ceiling (operands kept below 2^31)
package lane_pkg;

  localparam int MAX_MULT    = 4;
  localparam int COMBO_W     = 8;
  localparam int COMBO_SHIFT = 3;

  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned max_v);
    int unsigned s;
    s = a + b;
    return (s > max_v) ? max_v : s;
  endfunction

endpackage

// File: rtl/lane_slot.sv
// lane_slot
//   One falling-note slot: owns the active flag, the note y position and the
//   key edge register for its lane.
//   Ports:
//     clk_sys     in   clock
//     reset       in   synchronous, active-high
//     frame_tick  in   one-cycle pulse per frame; moves the note
//     spawn       in   load a fresh note at y=0 (only issued while inactive)
//     key         in   lane button level, already synchronised
//     next_x/y    in   pixel scan position
//     active      out  slot holds a note
//     hit         out  key rising edge with the note inside the hit window
//     miss        out  note leaves the window on this frame_tick
//     ghost       out  key rising edge with no note inside the window
//     in_pixel    out  registered: note covers the scan pixel
module lane_slot
  import lane_pkg::*;
#(
  parameter int Y_W     = 10,
  parameter int SPEED   = 2,
  parameter int HIT_Y   = 450,
  parameter int HIT_WIN = 16,
  parameter int NOTE_H  = 32,
  parameter int X_LO    = 160,
  parameter int X_HI    = 240
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       spawn,
  input  logic       key,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  output logic       active,
  output logic       hit,
  output logic       miss,
  output logic       ghost,
  output logic       in_pixel
);

  localparam int WIN_LO = HIT_Y - HIT_WIN;
  localparam int WIN_HI = HIT_Y + HIT_WIN;

  logic [Y_W-1:0] y;
  logic           key_q;
  logic           key_rise;
  logic           in_win;
  int             y_i;
  int             x_scan;
  int             y_scan;

  always_comb begin
    y_i      = int'(y);
    x_scan   = int'(next_x);
    y_scan   = int'(next_y);
    key_rise = key & ~key_q;
    in_win   = active && (y_i >= WIN_LO) && (y_i <= WIN_HI);
    hit      = key_rise && in_win;
    ghost    = key_rise && !in_win;
    // Judged on the pre-tick position; a hit this cycle suppresses the miss.
    miss     = active && frame_tick && !hit && ((y_i + SPEED) > WIN_HI);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      active   <= 1'b0;
      y        <= '0;
      key_q    <= 1'b0;
      in_pixel <= 1'b0;
    end else begin
      key_q    <= key;
      in_pixel <= active && (x_scan >= X_LO) && (x_scan < X_HI) &&
                  (y_scan >= y_i) && (y_scan < y_i + NOTE_H);
      if (spawn) begin
        active <= 1'b1;
        y      <= '0;
      end else if (hit || miss) begin
        active <= 1'b0;
        y      <= '0;
      end else if (active && frame_tick) begin
        y <= y + Y_W'(SPEED);
      end
    end
  end

endmodule

// File: rtl/lane_note_engine.sv
// lane_note_engine
//   N-lane falling-note engine: spawn handshake with the pattern list, per-lane
//   note slots, hit/miss judging, score and combo with a capped multiplier.
//   Optional build macro: GHOST_PENALTY_EN -- a key edge with no note in the
//   window clears combo (score untouched, no pulse). Undefined: ignored.
//   Ports:
//     CLOCK_25     in   pixel clock, only clock
//     reset        in   synchronous, active-high
//     frame_tick   in   one pulse per frame
//     spawn_valid  in   pattern list offers a spawn
//     spawn_lanes  in   lanes that receive a new note
//     spawn_ready  out  accepted when spawn_valid && spawn_ready
//     key_in       in   per-lane button levels
//     next_x/y     in   scan position
//     pixel_lane   out  registered per-lane note coverage of the scan pixel
//     score        out  saturating score (SCORE_W kept at or below 30)
//     combo        out  saturating combo count
//     hit_pulse    out  one-cycle pulse per lane hit
//     miss_pulse   out  one-cycle pulse per lane miss
module lane_note_engine
  import lane_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int Y_W     = 10,
  parameter int SPEED   = 2,
  parameter int HIT_Y   = 450,
  parameter int HIT_WIN = 16,
  parameter int NOTE_H  = 32,
  parameter int X0      = 160,
  parameter int LANE_W  = 80,
  parameter int SCORE_W = 16
) (
  input  logic               CLOCK_25,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               spawn_valid,
  input  logic [N_LANES-1:0] spawn_lanes,
  output logic               spawn_ready,
  input  logic [N_LANES-1:0] key_in,
  input  logic [9:0]         next_x,
  input  logic [9:0]         next_y,
  output logic [N_LANES-1:0] pixel_lane,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         combo,
  output logic [N_LANES-1:0] hit_pulse,
  output logic [N_LANES-1:0] miss_pulse
);

  localparam int unsigned SCORE_MAX = (32'd1 << SCORE_W) - 32'd1;
  localparam int unsigned COMBO_MAX = (32'd1 << COMBO_W) - 32'd1;

  logic [N_LANES-1:0] active;
  logic [N_LANES-1:0] hit;
  logic [N_LANES-1:0] miss;
  logic [N_LANES-1:0] ghost;
  logic               spawn_fire;
  logic               combo_clear;
  int unsigned        n_hits;
  int unsigned        pts;
  int unsigned        score_nx;
  int unsigned        combo_nx;

  // Spawns are held off during frame_tick so a new note never moves on its
  // first cycle, and never land on a lane that still holds a note.
  assign spawn_ready = !frame_tick && ((spawn_lanes & active) == '0);
  assign spawn_fire  = spawn_valid && spawn_ready;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    lane_slot #(
      .Y_W    (Y_W),
      .SPEED  (SPEED),
      .HIT_Y  (HIT_Y),
      .HIT_WIN(HIT_WIN),
      .NOTE_H (NOTE_H),
      .X_LO   (X0 + i * LANE_W),
      .X_HI   (X0 + (i + 1) * LANE_W)
    ) u_slot (
      .clk_sys   (CLOCK_25),
      .reset     (reset),
      .frame_tick(frame_tick),
      .spawn     (spawn_fire && spawn_lanes[i]),
      .key       (key_in[i]),
      .next_x    (next_x),
      .next_y    (next_y),
      .active    (active[i]),
      .hit       (hit[i]),
      .miss      (miss[i]),
      .ghost     (ghost[i]),
      .in_pixel  (pixel_lane[i])
    );
  end

`ifdef GHOST_PENALTY_EN
  assign combo_clear = (|miss) || (|ghost);
`else
  logic unused_ghost;
  assign unused_ghost = |ghost;
  assign combo_clear  = |miss;
`endif

  // Every hit in a cycle earns the same points, taken from the combo at the
  // start of the cycle, so the sum is a simple product.
  always_comb begin
    n_hits = $countones(hit);
    pts    = 32'd1 + (32'(combo) >> COMBO_SHIFT);
    if (pts > MAX_MULT) pts = MAX_MULT;
    score_nx = sat_add(32'(score), n_hits * pts, SCORE_MAX);
    combo_nx = combo_clear ? 32'd0 : sat_add(32'(combo), n_hits, COMBO_MAX);
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      score      <= '0;
      combo      <= '0;
      hit_pulse  <= '0;
      miss_pulse <= '0;
    end else begin
      score      <= SCORE_W'(score_nx);
      combo      <= 8'(combo_nx);
      hit_pulse  <= hit;
      miss_pulse <= miss;
    end
  end

endmodule

// File: tb/tb_lane_note_engine.sv
module tb_lane_note_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        spawn_valid;
  logic [3:0]  spawn_lanes;
  logic [3:0]  key_in;
  logic [9:0]  next_x;
  logic [9:0]  next_y;

  logic        spawn_ready;
  logic [3:0]  pixel_lane;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [3:0]  hit_pulse;
  logic [3:0]  miss_pulse;

  logic        spawn_ready_s;
  logic [3:0]  pixel_lane_s;
  logic [7:0]  score_s;
  logic [7:0]  combo_s;
  logic [3:0]  hit_pulse_s;
  logic [3:0]  miss_pulse_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lane_note_engine dut (
    .CLOCK_25   (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .spawn_valid(spawn_valid),
    .spawn_lanes(spawn_lanes),
    .spawn_ready(spawn_ready),
    .key_in     (key_in),
    .next_x     (next_x),
    .next_y     (next_y),
    .pixel_lane (pixel_lane),
    .score      (score),
    .combo      (combo),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse)
  );

  // Same stimulus into a narrow-score copy so saturation is reachable quickly.
  lane_note_engine #(.SCORE_W(8)) dut_sat (
    .CLOCK_25   (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .spawn_valid(spawn_valid),
    .spawn_lanes(spawn_lanes),
    .spawn_ready(spawn_ready_s),
    .key_in     (key_in),
    .next_x     (next_x),
    .next_y     (next_y),
    .pixel_lane (pixel_lane_s),
    .score      (score_s),
    .combo      (combo_s),
    .hit_pulse  (hit_pulse_s),
    .miss_pulse (miss_pulse_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spawn(input logic [3:0] mask);
    spawn_valid = 1'b1;
    spawn_lanes = mask;
    step();
    spawn_valid = 1'b0;
    spawn_lanes = '0;
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) step();
    frame_tick = 1'b0;
  endtask

  // Spawn, fall 220 frames to y=440, press, and check the outcome.
  task automatic round(input logic [3:0] mask, input int exp_score,
                       input int exp_combo, input string tag);
    spawn(mask);
    ticks(220);
    key_in = mask;
    step();
    chk({tag, "_hit"}, 32'(hit_pulse), 32'(mask));
    chk({tag, "_score"}, 32'(score), exp_score);
    chk({tag, "_combo"}, 32'(combo), exp_combo);
    chk({tag, "_sat_score"}, 32'(score_s), (exp_score > 255) ? 255 : exp_score);
    chk({tag, "_sat_hit"}, 32'(hit_pulse_s), 32'(mask));
    key_in = '0;
    step();
  endtask

  initial begin
    reset       = 1'b1;
    frame_tick  = 1'b0;
    spawn_valid = 1'b0;
    spawn_lanes = '0;
    key_in      = '0;
    next_x      = '0;
    next_y      = '0;
    step();
    step();
    chk("rst_score", 32'(score), 0);
    chk("rst_combo", 32'(combo), 0);
    chk("rst_hit", 32'(hit_pulse), 0);
    chk("rst_miss", 32'(miss_pulse), 0);
    chk("rst_pixel", 32'(pixel_lane), 0);
    chk("rst_ready", 32'(spawn_ready), 1);
    reset = 1'b0;
    step();

    // First note: pixel window edges, then a hit at y=440.
    spawn(4'b0001);
    ticks(220);
    next_x = 10'd170; next_y = 10'd450; step();
    chk("pix_mid", 32'(pixel_lane), 1);
    next_y = 10'd439; step();
    chk("pix_above", 32'(pixel_lane), 0);
    next_y = 10'd471; step();
    chk("pix_last_row", 32'(pixel_lane), 1);
    next_y = 10'd472; step();
    chk("pix_below", 32'(pixel_lane), 0);
    next_x = 10'd240; next_y = 10'd450; step();
    chk("pix_lane1_x", 32'(pixel_lane), 0);
    next_x = 10'd239; step();
    chk("pix_last_col", 32'(pixel_lane), 1);
    key_in = 4'b0001;
    step();
    chk("t1_hit", 32'(hit_pulse), 1);
    chk("t1_score", 32'(score), 1);
    chk("t1_combo", 32'(combo), 1);
    key_in = '0;
    step();
    chk("t1_pulse_len", 32'(hit_pulse), 0);
    chk("t1_cleared", 32'(pixel_lane), 0);

    round(4'b1101, 4, 4, "r_a");
    round(4'b0001, 5, 5, "r_b");

    // Miss: lane 1 sits at y=466 after 233 frames, leaves on frame 234.
    spawn(4'b0010);
    ticks(233);
    chk("miss_early", 32'(miss_pulse), 0);
    chk("miss_early_combo", 32'(combo), 5);
    ticks(1);
    chk("miss_pulse", 32'(miss_pulse), 4'b0010);
    chk("miss_combo", 32'(combo), 0);
    chk("miss_score", 32'(score), 5);
    step();
    chk("miss_pulse_len", 32'(miss_pulse), 0);

    // Handshake.
    spawn(4'b0100);
    spawn_valid = 1'b1; spawn_lanes = 4'b0100; #1;
    chk("rdy_busy_lane", 32'(spawn_ready), 0);
    spawn_lanes = 4'b1000; frame_tick = 1'b1; #1;
    chk("rdy_frame_tick", 32'(spawn_ready), 0);
    frame_tick = 1'b0; #1;
    chk("rdy_free_lane", 32'(spawn_ready), 1);
    step();
    chk("rdy_lane3_taken", 32'(spawn_ready), 0);
    spawn_lanes = 4'b0000; #1;
    chk("rdy_empty_mask", 32'(spawn_ready), 1);
    spawn_valid = 1'b0;
    ticks(220);
    key_in = 4'b1100;
    step();
    chk("hs_hit", 32'(hit_pulse), 4'b1100);
    chk("hs_score", 32'(score), 7);
    chk("hs_combo", 32'(combo), 2);
    key_in = '0;
    step();

    // Multiplier steps: combo 8 -> 2 points, combo 32 -> capped at 4.
    round(4'b1111, 11, 6, "m_a");
    round(4'b0011, 13, 8, "m_b");
    round(4'b0001, 15, 9, "m_ninth");
    round(4'b1111, 23, 13, "m_c");
    round(4'b1111, 31, 17, "m_d");
    round(4'b1111, 43, 21, "m_e");
    round(4'b1111, 55, 25, "m_f");
    round(4'b1111, 71, 29, "m_g");
    round(4'b0011, 79, 31, "m_h");
    round(4'b0001, 83, 32, "m_c31");
    round(4'b0001, 87, 33, "m_cap");

    // Clear combo, rebuild to 8, then hits on 0/2 with a miss on 1 together.
    spawn(4'b0010);
    ticks(234);
    chk("mx_pre_combo", 32'(combo), 0);
    round(4'b1111, 91, 4, "mx_a");
    round(4'b1111, 95, 8, "mx_b");
    spawn(4'b0111);
    ticks(233);
    frame_tick = 1'b1; key_in = 4'b0101;
    step();
    chk("mx_hit", 32'(hit_pulse), 4'b0101);
    chk("mx_miss", 32'(miss_pulse), 4'b0010);
    chk("mx_score", 32'(score), 99);
    chk("mx_combo", 32'(combo), 0);
    frame_tick = 1'b0; key_in = '0;
    step();

    // Hit on the same cycle as frame_tick.
    spawn(4'b0001);
    ticks(219);
    frame_tick = 1'b1; key_in = 4'b0001;
    step();
    chk("ht_hit", 32'(hit_pulse), 1);
    chk("ht_miss", 32'(miss_pulse), 0);
    chk("ht_score", 32'(score), 100);
    chk("ht_combo", 32'(combo), 1);
    frame_tick = 1'b0; key_in = '0;
    step();

    // Drive the 8-bit copy through saturation.
    round(4'b1111, 104, 5, "s_01");
    round(4'b1111, 108, 9, "s_02");
    round(4'b1111, 116, 13, "s_03");
    round(4'b1111, 124, 17, "s_04");
    round(4'b1111, 136, 21, "s_05");
    round(4'b1111, 148, 25, "s_06");
    round(4'b1111, 164, 29, "s_07");
    round(4'b1111, 180, 33, "s_08");
    round(4'b1111, 196, 37, "s_09");
    round(4'b1111, 212, 41, "s_10");
    round(4'b1111, 228, 45, "s_11");
    round(4'b1111, 244, 49, "s_12");
    round(4'b1111, 260, 53, "s_13");
    round(4'b1111, 276, 57, "s_14");

    // Reset with three notes in flight.
    spawn(4'b0111);
    ticks(100);
    next_x = 10'd170; next_y = 10'd210; step();
    chk("rm_pix_before", 32'(pixel_lane), 1);
    reset = 1'b1;
    step();
    chk("rm_score", 32'(score), 0);
    chk("rm_combo", 32'(combo), 0);
    chk("rm_hit", 32'(hit_pulse), 0);
    chk("rm_miss", 32'(miss_pulse), 0);
    chk("rm_sat_score", 32'(score_s), 0);
    reset = 1'b0;
    step();
    chk("rm_pix_after", 32'(pixel_lane), 0);
    spawn_lanes = 4'b0111; #1;
    chk("rm_ready", 32'(spawn_ready), 1);
    spawn_lanes = '0;
    ticks(200);
    chk("rm_no_miss", 32'(miss_pulse), 0);

    // Ghost press at combo 6.
    round(4'b1111, 4, 4, "g_a");
    round(4'b0011, 6, 6, "g_b");
    key_in = 4'b0100;
    step();
    chk("g_hit", 32'(hit_pulse), 0);
    chk("g_score", 32'(score), 6);
`ifdef GHOST_PENALTY_EN
    chk("g_combo", 32'(combo), 0);
`else
    chk("g_combo", 32'(combo), 6);
`endif
    key_in = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
